// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: decodes the PC region into IMEM/BIOS read enables,
// aligns the source select with the 1-cycle read latency, holds the instruction across stalls
// and records unmapped fetches. Optional macro IF_ALIGN_CHECK_EN adds a misaligned-PC fault.
module if_fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter int unsigned       TAG_W    = 4,
    parameter logic [TAG_W-1:0]  IMEM_TAG = 4'b0001,
    parameter logic [TAG_W-1:0]  BIOS_TAG = 4'b0100,
    parameter int unsigned       INST_W   = 32,
    parameter logic [INST_W-1:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned       CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              stall,
    input  logic [INST_W-1:0] imem_dout,
    input  logic [INST_W-1:0] bios_dout,
    input  logic              fault_clr,
    output logic              imem_re,
    output logic              bios_re,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_pc,
    output logic [CNT_W-1:0]  fault_cnt
);

    typedef enum logic [1:0] {SRC_NONE, SRC_IMEM, SRC_BIOS} src_e;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HOLD} state_e;

    state_e              state_q, state_d;
    src_e                src_q, src_d, src_dec;
    logic [INST_W-1:0]   hold_q, hold_d;
    logic                hold_v_q, hold_v_d;
    logic                fault_q, fault_d;
    logic [ADDR_W-1:0]   fault_pc_q, fault_pc_d;
    logic [CNT_W-1:0]    fault_cnt_q, fault_cnt_d;

    logic [TAG_W-1:0]    tag;
    logic                misalign;
    logic                fetch;
    logic                fault_hit;
    logic [INST_W-1:0]   run_inst;

    // Region decode; a misaligned PC (when checked) is treated as unmapped
    always_comb begin
        tag = pc[ADDR_W-1 -: TAG_W];
`ifdef IF_ALIGN_CHECK_EN
        misalign = (pc[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        fetch   = !reset && !stall;
        src_dec = SRC_NONE;
        if (!misalign && tag == IMEM_TAG)      src_dec = SRC_IMEM;
        else if (!misalign && tag == BIOS_TAG) src_dec = SRC_BIOS;
        imem_re   = fetch && (src_dec == SRC_IMEM);
        bios_re   = fetch && (src_dec == SRC_BIOS);
        fault_hit = fetch && (src_dec == SRC_NONE);
        src_d     = fetch ? src_dec : src_q;
    end

    always_comb begin
        case (src_q)
            SRC_IMEM: run_inst = imem_dout;
            SRC_BIOS: run_inst = bios_dout;
            default:  run_inst = NOP_INST;
        endcase
    end

    // Next-state and instruction output; HOLD replays the captured word until release
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        inst       = NOP_INST;
        inst_valid = 1'b0;
        case (state_q)
            ST_BOOT: begin
                if (!stall) state_d = ST_RUN;
            end
            ST_RUN: begin
                inst       = run_inst;
                inst_valid = (src_q != SRC_NONE);
                if (stall) begin
                    hold_d   = run_inst;
                    hold_v_d = (src_q != SRC_NONE);
                    state_d  = ST_HOLD;
                end
            end
            ST_HOLD: begin
                inst       = hold_q;
                inst_valid = hold_v_q;
                if (!stall) state_d = ST_RUN;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    // Fault bookkeeping; a fault on the clearing edge wins over the clear
    always_comb begin
        fault_d     = fault_q;
        fault_pc_d  = fault_pc_q;
        fault_cnt_d = fault_cnt_q;
        if (fault_hit) begin
            fault_d = 1'b1;
            if (fault_clr) begin
                fault_pc_d  = pc;
                fault_cnt_d = CNT_W'(1);
            end else begin
                if (!fault_q) fault_pc_d = pc;
                if (fault_cnt_q != {CNT_W{1'b1}}) fault_cnt_d = fault_cnt_q + CNT_W'(1);
            end
        end else if (fault_clr) begin
            fault_d     = 1'b0;
            fault_pc_d  = '0;
            fault_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_BOOT;
            src_q       <= SRC_NONE;
            hold_q      <= NOP_INST;
            hold_v_q    <= 1'b0;
            fault_q     <= 1'b0;
            fault_pc_q  <= '0;
            fault_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            hold_q      <= hold_d;
            hold_v_q    <= hold_v_d;
            fault_q     <= fault_d;
            fault_pc_q  <= fault_pc_d;
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault     = fault_q;
    assign fault_pc  = fault_pc_q;
    assign fault_cnt = fault_cnt_q;

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Parametrised instruction-fetch controller between the PC stage and the instruction memories (IMEM block RAM and BIOS ROM, both 1-cycle synchronous read).
- Decodes the PC region tag into per-memory read enables.
- Registers the source select so it aligns with the 1-cycle memory read latency.
- Holds the fetched instruction across stalls.
- Records fetches to unmapped regions: sticky flag, first faulting PC, saturating count.

Parameters:
ADDR_W, 32, PC width
TAG_W, 4, number of PC MSBs used as the region tag
IMEM_TAG, 4'b0001, tag value selecting IMEM
BIOS_TAG, 4'b0100, tag value selecting BIOS
INST_W, 32, instruction width
NOP_INST, 32'h0000_0000, instruction driven when no valid source
CNT_W, 8, fault counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
pc  in  ADDR_W  fetch address for this cycle
stall  in  1  pipeline stall; freezes fetch
imem_dout  in  INST_W  IMEM read data (valid 1 cycle after imem_re)
bios_dout  in  INST_W  BIOS read data (valid 1 cycle after bios_re)
fault_clr  in  1  clears fault, fault_pc, fault_cnt
imem_re  out  1  IMEM read enable
bios_re  out  1  BIOS read enable
inst  out  INST_W  instruction for decode stage
inst_valid  out  1  inst is a real fetched instruction
fault  out  1  sticky unmapped-fetch flag
fault_pc  out  ADDR_W  PC of the first fault since the last clear
fault_cnt  out  CNT_W  saturating count of faulting fetches

Behaviour:
- Decode is combinational. tag = pc[ADDR_W-1 -: TAG_W]. A fetch cycle is any cycle with reset=0 and stall=0.
- imem_re = fetch cycle && tag==IMEM_TAG. bios_re = fetch cycle && tag==BIOS_TAG. Both are 0 whenever reset=1 or stall=1. Both are never 1 together; IMEM_TAG != BIOS_TAG is a parameter legality requirement.
- src_q (2-bit register: NONE/IMEM/BIOS) loads the decoded source on each fetch-cycle edge. Stall edges leave it unchanged. Reset value is NONE.
- FSM states: BOOT, RUN, HOLD. Async reset forces BOOT.
  - BOOT: inst=NOP_INST, inst_valid=0. The first fetch-cycle edge moves to RUN. A stall edge stays in BOOT.
  - RUN: inst = imem_dout if src_q=IMEM, bios_dout if src_q=BIOS, NOP_INST if src_q=NONE. inst_valid=1 iff src_q!=NONE.
  - RUN with stall=1: at the edge, hold_q captures the current inst and hold_v captures inst_valid; move to HOLD.
  - HOLD: inst=hold_q, inst_valid=hold_v, regardless of memory outputs. The hold does not rely on the RAMs retaining data.
  - HOLD with stall=0: the read enables for pc assert in that cycle. Outputs stay hold_q/hold_v for that cycle. At the edge, src_q updates and the FSM moves to RUN.
- Latency: the instruction for pc fetched at edge N appears on inst during cycle N+1. Stalls insert no bubbles and lose no instructions.
- Fault detection, on fetch-cycle edges with tag matching neither IMEM_TAG nor BIOS_TAG:
  - fault <= 1.
  - fault_pc <= pc only if fault was 0 before the edge (first fault is kept).
  - fault_cnt increments and saturates at all ones.
  - The fetch still proceeds as src NONE (inst=NOP, inst_valid=0).
- Stall cycles never count as faults.
- fault_clr=1 at an edge: fault=0, fault_pc=0, fault_cnt=0. If the same edge also sees a fault, the new fault wins: fault=1, fault_pc=pc, fault_cnt=1.
- Reset values: imem_re=0, bios_re=0, inst=NOP_INST, inst_valid=0, fault=0, fault_pc=0, fault_cnt=0, hold_q=NOP_INST, hold_v=0.
- Reset asserted mid-HOLD or mid-fetch returns to BOOT immediately; the in-flight instruction is discarded.

Optional Feature:
IF_ALIGN_CHECK_EN
- Defined: a fetch cycle with pc[1:0]!=2'b00 is a fault even in a mapped region. It forces imem_re=bios_re=0, src NONE, and follows the normal fault/fault_pc/fault_cnt update.
- Undefined: pc[1:0] is ignored by this block.

Test Plan:
- Reset, then pc=0x1000_0000, stall=0, imem_dout=0xAAAA0001 -> cycle 1 imem_re=1, bios_re=0; cycle 2 inst=0xAAAA0001, inst_valid=1, FSM RUN.
- pc=0x4000_0010, bios_dout=0xB105_0000 -> bios_re=1; next cycle inst=0xB105_0000. Switch to pc=0x1000_0004 -> source changes exactly one cycle after pc.
- In RUN showing 0x1234_5678, stall=1 for 3 cycles while imem_dout changes to 0xDEAD_BEEF -> inst stays 0x1234_5678, inst_valid=1, imem_re=0 throughout; release -> next fetched instruction appears one cycle later.
- pc=0x2000_0000 fetch, then pc=0xF000_0000 fetch -> fault=1, fault_pc=0x2000_0000, fault_cnt=2, inst_valid=0. fault_clr together with a third bad fetch at 0x3000_0000 -> fault=1, fault_pc=0x3000_0000, fault_cnt=1.
- 300 consecutive unmapped fetches with CNT_W=8 -> fault_cnt saturates at 255. A stall during a bad pc adds no count.
- Reset asserted mid-HOLD -> outputs immediately NOP_INST/0, enables 0. With IF_ALIGN_CHECK_EN, pc=0x1000_0002 -> imem_re=0, fault=1, fault_pc=0x1000_0002.
